// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller for the synchronous FIFO. It issues reads into the
// FIFO's read port, which has one cycle of latency, and catches the returned
// words in a 2-entry skid buffer. The buffer head is presented downstream as a
// valid/ready stream, so the consumer never sees the FIFO's read latency and
// one word per cycle can be sustained. The block also counts delivered words
// and FIFO underflow events.
//
// Ports
//   clk               single clock, posedge
//   rst_n             asynchronous active-low reset
//   enable            1: fetch from FIFO; 0: stop issuing reads and drain
//   fifo_data_out     FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty        FIFO empty flag for the current cycle
//   fifo_almostempty  FIFO holds exactly one word (status only, not used for gating)
//   fifo_underflow    FIFO flagged the previous cycle's read as an underflow
//   fifo_rd_en        read strobe to the FIFO (combinational)
//   out_data          downstream data, taken from the skid buffer head
//   out_valid         out_data holds a word
//   out_ready         downstream accepts the word
//   busy              controller is not idle
//   rd_count          words delivered downstream, wraps
//   underflow_cnt     underflow events, saturates at all-ones
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_almostempty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  underflow_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   busy_q;
    logic                   inflight_q;
    logic [1:0]             occ_q, occ_d;
    logic                   valid_q;
    logic [FIFO_WIDTH-1:0]  head_q, head_d;
    logic [FIFO_WIDTH-1:0]  tail_q, tail_d;
    logic [CNT_WIDTH-1:0]   rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0]   uf_cnt_q, uf_cnt_d;

    logic                   pop_s;
    logic                   push_s;
    logic                   uf_event_s;
    logic [2:0]             level_s;
    logic                   almostempty_unused_s;

    // The almost-empty flag is carried for the external monitor only.
    assign almostempty_unused_s = fifo_almostempty;

    // Handshake and return-path decode. A returned word is kept only when a
    // read is actually in flight; an underflow with nothing in flight is noise.
    assign pop_s      = valid_q & out_ready;
    assign push_s     = inflight_q & ~fifo_underflow;
    assign uf_event_s = inflight_q & fifo_underflow;

    // Words that will still occupy the buffer after this cycle's pop; a new
    // read may only be issued if its returning word is guaranteed a slot.
    assign level_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};

    // FSM state register; busy is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (!inflight_q && (occ_q == 2'd0)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: read strobe, never speculative against an empty FIFO.
    always_comb begin
        fifo_rd_en = 1'b0;
        if ((state_q == ST_RUN) && !fifo_empty && (level_s < 3'd2)) begin
            fifo_rd_en = 1'b1;
        end else begin
            fifo_rd_en = 1'b0;
        end
    end

    // Skid buffer next-state: head is always the oldest word, tail the second.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_data_out;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    tail_d = fifo_data_out;
                    occ_d  = 2'd2;
                end else begin
                    occ_d  = occ_q;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever
                // remains after the pop.
                if (occ_q == 2'd1) begin
                    head_d = fifo_data_out;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_data_out;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Counter next-state: delivered words wrap, underflows saturate.
    always_comb begin
        rd_count_d = rd_count_q;
        uf_cnt_d   = uf_cnt_q;
        if (pop_s) begin
            rd_count_d = rd_count_q + CNT_WIDTH'(1);
        end else begin
            rd_count_d = rd_count_q;
        end
        if (uf_event_s && (uf_cnt_q != {CNT_WIDTH{1'b1}})) begin
            uf_cnt_d = uf_cnt_q + CNT_WIDTH'(1);
        end else begin
            uf_cnt_d = uf_cnt_q;
        end
    end

    // Datapath and bookkeeping registers; out_valid tracks occupancy directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            valid_q    <= 1'b0;
            head_q     <= {FIFO_WIDTH{1'b0}};
            tail_q     <= {FIFO_WIDTH{1'b0}};
            rd_count_q <= {CNT_WIDTH{1'b0}};
            uf_cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            inflight_q <= fifo_rd_en;
            occ_q      <= occ_d;
            valid_q    <= (occ_d != 2'd0);
            head_q     <= head_d;
            tail_q     <= tail_d;
            rd_count_q <= rd_count_d;
            uf_cnt_q   <= uf_cnt_d;
        end
    end

    assign out_data      = head_q;
    assign out_valid     = valid_q;
    assign busy          = busy_q;
    assign rd_count      = rd_count_q;
    assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Self-checking bench for fifo_rd_ctrl. A behavioural FIFO (queue with one
// cycle of read latency) feeds the DUT. The reference model tracks, as plain
// counts and a queue, the words owed to the consumer, whether the block is
// running, and whether it still has work outstanding. Every cycle the DUT's
// read strobe, stream outputs, busy flag and counters are compared against it.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_empty;
    logic          fifo_almostempty;
    logic          fifo_underflow;
    logic          fifo_rd_en;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] underflow_cnt;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .fifo_data_out    (fifo_data_out),
        .fifo_empty       (fifo_empty),
        .fifo_almostempty (fifo_almostempty),
        .fifo_underflow   (fifo_underflow),
        .fifo_rd_en       (fifo_rd_en),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .rd_count         (rd_count),
        .underflow_cnt    (underflow_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] fifo_mem[$];   // contents of the behavioural FIFO
    logic [W-1:0] exp_q[$];      // words accepted from the FIFO, not yet delivered
    bit           run_m;         // enable was high at the last edge
    bit           busy_m;
    bit           infl_m;        // a read was issued last cycle
    int unsigned  cnt_m;
    int unsigned  uf_m;
    bit           last_rd;       // DUT read strobe seen in the most recent step

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_flags();
        fifo_empty       = (fifo_mem.size() == 0);
        fifo_almostempty = (fifo_mem.size() == 1);
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_mem.push_back(w);
        fifo_flags();
    endtask

    // One clock cycle: compare at the falling edge, advance the model to the
    // state after the coming rising edge, then update the FIFO side.
    task automatic step();
        bit exp_rd;
        bit pop;
        int outst;
        @(negedge clk);
        outst  = exp_q.size() + int'(infl_m);
        pop    = (exp_q.size() != 0) && out_ready;
        exp_rd = run_m && !fifo_empty && ((outst - int'(pop)) < 2);
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
        chk("busy", 32'(busy), 32'(busy_m));
        chk("rd_count", 32'(rd_count), 32'(cnt_m[CW-1:0]));
        chk("underflow_cnt", 32'(underflow_cnt), 32'(uf_m));
        last_rd = fifo_rd_en;
        if (pop) begin
            void'(exp_q.pop_front());
            cnt_m++;
        end
        if (infl_m) begin
            if (fifo_underflow) begin
                if (uf_m != 32'd65535) uf_m++;
            end else begin
                exp_q.push_back(fifo_data_out);
            end
        end
        busy_m = enable || run_m || (busy_m && (outst != 0));
        run_m  = enable;
        infl_m = exp_rd;
        @(posedge clk);
        #1;
        if (last_rd && (fifo_mem.size() != 0)) fifo_data_out = fifo_mem.pop_front();
        else fifo_data_out = W'($urandom);
        fifo_underflow = 1'b0;
        fifo_flags();
    endtask

    task automatic drain(input string tag);
        enable    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (busy_m || busy); i++) step();
        step();
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        run_m  = 1'b0;
        busy_m = 1'b0;
        infl_m = 1'b0;
        cnt_m  = 0;
        uf_m   = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rd_en"},     32'(fifo_rd_en),    32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid),     32'd0);
        chk({tag, "_out_data"},  32'(out_data),      32'd0);
        chk({tag, "_busy"},      32'(busy),          32'd0);
        chk({tag, "_rd_count"},  32'(rd_count),      32'd0);
        chk({tag, "_uf_cnt"},    32'(underflow_cnt), 32'd0);
    endtask

    initial begin
        int n_rd;
        int first_rd;
        int last_rd_cyc;
        int unsigned uf_before;

        rst_n          = 1'b0;
        enable         = 1'b0;
        out_ready      = 1'b0;
        fifo_underflow = 1'b0;
        fifo_data_out  = '0;
        last_rd        = 1'b0;
        fifo_flags();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming: 8 words, consumer always ready.
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        enable    = 1'b1;
        out_ready = 1'b1;
        n_rd = 0; first_rd = -1; last_rd_cyc = -1;
        for (int c = 0; c < 14; c++) begin
            step();
            if (last_rd) begin
                n_rd++;
                if (first_rd < 0) first_rd = c;
                last_rd_cyc = c;
            end
        end
        chk("stream_reads", 32'(n_rd), 32'd8);
        chk("stream_consecutive", 32'(last_rd_cyc - first_rd), 32'd7);
        chk("stream_rd_count", 32'(rd_count), 32'd8);
        drain("stream_idle");

        // Backpressure: 6 words, consumer stalls for cycles 3..10.
        for (int i = 0; i < 6; i++) push_word(W'(16'h0A00 + i));
        enable = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            out_ready = !(c >= 3 && c <= 10);
            step();
        end
        chk("bp_rd_count", 32'(rd_count), 32'd14);
        drain("bp_idle");

        // Empty edge: a single word, then the FIFO stays empty.
        push_word(16'h0BEE);
        enable = 1'b1;
        n_rd   = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (last_rd) n_rd++;
        end
        chk("single_reads", 32'(n_rd), 32'd1);
        chk("single_uf", 32'(underflow_cnt), 32'd0);
        drain("single_idle");

        // Forced underflow on a real read, then a spurious one with nothing in flight.
        uf_before = uf_m;
        push_word(16'h0C01);
        push_word(16'h0C02);
        enable = 1'b1;
        last_rd = 1'b0;
        for (int c = 0; c < 10 && !last_rd; c++) step();
        chk("uf_read_seen", 32'(last_rd), 32'd1);
        fifo_underflow = 1'b1;
        step();
        for (int c = 0; c < 6; c++) step();
        chk("uf_count", 32'(underflow_cnt), 32'(uf_before + 1));
        drain("uf_idle");
        fifo_underflow = 1'b1;
        step();
        step();
        chk("uf_spurious", 32'(underflow_cnt), 32'(uf_before + 1));

        // Drain: enable drops the cycle after a read while one word is buffered.
        for (int i = 0; i < 3; i++) push_word(W'(16'h0D00 + i));
        enable    = 1'b1;
        out_ready = 1'b0;
        last_rd   = 1'b0;
        for (int c = 0; c < 10 && !(last_rd && exp_q.size() == 1); c++) step();
        enable = 1'b0;
        step();
        step();
        chk("drain_busy", 32'(busy), 32'd1);
        drain("drain_idle");

        // Reset mid-transfer with the skid buffer full.
        for (int i = 0; i < 6; i++) push_word(W'(16'h0E00 + i));
        enable    = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) step();
        chk("rst_pre_occ", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) step();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            enable         = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            fifo_underflow = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) push_word(W'($urandom));
            step();
        end
        drain("rand_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
